// File: rtl/fetch_pipe_pkg.sv
// Shared types and default parameters for the instruction fetch pipeline.
package fetch_pipe_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam int unsigned DEF_PC_INC   = 2;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; used for the
// prefetch buffer and the in-order tag queue of outstanding fetch PCs.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic [PW:0]      cnt_d;
  logic             valid_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != (PW+1)'(DEPTH)) || do_pop);
    cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_pipe.sv
// Instruction fetch front end: issues in-order memory reads, buffers the
// returned instructions with their PCs, and handles redirect, halt and errors.
module fetch_pipe
  import fetch_pipe_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter int unsigned       PC_INC   = DEF_PC_INC,
  parameter int unsigned       DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_err,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  inc_PC,
  output logic               err
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned SW      = CW + 1;
  localparam int unsigned ALIGN_W = $clog2(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_W) - 64'd1);
  localparam int unsigned EW      = INSTR_W + 2 * ADDR_W;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] pc_q,   pc_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              err_q,  err_d;

  logic              accept, tag_pop, tag_valid, live, redir, err_evt, enq, deq, fits;
  logic [ADDR_W-1:0] tag_pc;
  logic [CW-1:0]     outst, occ, outst_nx, occ_nx;
  logic [EW-1:0]     entry_in, entry_out;

  // Handshake decode and next-cycle occupancy used to throttle requests.
  always_comb begin
    accept   = req_q && imem_gnt;
    tag_pop  = imem_rvalid && tag_valid;
    live     = (state_q != ST_ERROR);
    redir    = redirect_valid && live;
    err_evt  = live && ((redirect_valid && ((redirect_pc & ALIGN_MASK) != '0)) ||
                        (imem_rvalid && imem_err));
    enq      = live && tag_pop && (drop_q == '0) && !redir && !err_evt;
    deq      = instr_valid && instr_ready && !redir;
    outst_nx = outst + CW'(accept) - CW'(tag_pop);
    occ_nx   = redir ? '0 : (occ + CW'(enq) - CW'(deq));
    fits     = (SW'(occ_nx) + SW'(outst_nx)) < SW'(DEPTH);
  end

  // PC, drop counter and sticky error; a redirect drops every read still in flight.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    err_d  = err_q | err_evt;
    if (redir) begin
      pc_d   = redirect_pc;
      drop_d = outst_nx;
    end else begin
      if (accept)                        pc_d   = pc_q + ADDR_W'(PC_INC);
      if (tag_pop && (drop_q != '0))     drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  // Control FSM; imem_req is registered from the next-cycle fit check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (err_evt) begin
            state_q <= ST_ERROR;
            req_q   <= 1'b0;
          end else if (redir) begin
            state_q <= ST_RUN;
            req_q   <= fits;
          end else if (halt) begin
            state_q <= ST_DRAIN;
            req_q   <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            req_q   <= fits;
          end
        end
        ST_DRAIN: begin
          if (err_evt) begin
            state_q <= ST_ERROR;
            req_q   <= 1'b0;
          end else if (redir) begin
            state_q <= ST_RUN;
            req_q   <= fits;
          end else begin
            state_q <= (outst_nx == '0) ? ST_HALTED : ST_DRAIN;
            req_q   <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (err_evt) begin
            state_q <= ST_ERROR;
            req_q   <= 1'b0;
          end else if (redir) begin
            state_q <= ST_RUN;
            req_q   <= fits;
          end else begin
            state_q <= ST_HALTED;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_ERROR;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (accept),
    .data_i  (pc_q),
    .pop_i   (tag_pop),
    .data_o  (tag_pc),
    .valid_o (tag_valid),
    .count_o (outst)
  );

  assign entry_in = {imem_rdata, tag_pc, tag_pc + ADDR_W'(PC_INC)};

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redir),
    .push_i  (enq),
    .data_i  (entry_in),
    .pop_i   (deq),
    .data_o  (entry_out),
    .valid_o (instr_valid),
    .count_o (occ)
  );

  assign instr     = entry_out[EW-1 -: INSTR_W];
  assign instr_pc  = entry_out[2*ADDR_W-1 -: ADDR_W];
  assign inc_PC    = entry_out[ADDR_W-1:0];
  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign err       = err_q;

endmodule

// File: doc/fetch_pipe.md
FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 Parameter ADDR_W, default 16: PC and memory address width.
REQ-002 Parameter INSTR_W, default 16: instruction width.
REQ-003 Parameter PC_INC, default 2: byte increment per sequential fetch.
REQ-004 Parameter DEPTH, default 4: prefetch buffer entries, power of two, >=2.
REQ-005 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-006 The block SHALL have a single clock and an asynchronous, active-high reset, as listed in REQ-007 and REQ-008.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 redirect_valid  in  1  branch/jump redirect strobe.
REQ-010 redirect_pc  in  ADDR_W  redirect target.
REQ-011 halt  in  1  stop fetching; level-sampled.
REQ-012 imem_req  out  1  memory read request.
REQ-013 imem_addr  out  ADDR_W  request address; equals current PC.
REQ-014 imem_gnt  in  1  request accepted this cycle when imem_req=1.
REQ-015 imem_rvalid  in  1  read data valid; responses return in request order.
REQ-016 imem_rdata  in  INSTR_W  read data.
REQ-017 imem_err  in  1  read error, qualified by imem_rvalid.
REQ-018 instr_valid  out  1  buffer head valid.
REQ-019 instr_ready  in  1  decode accepts head.
REQ-020 instr  out  INSTR_W  head instruction.
REQ-021 instr_pc  out  ADDR_W  head PC.
REQ-022 inc_PC  out  ADDR_W  instr_pc+PC_INC, modulo 2^ADDR_W.
REQ-023 err  out  1  sticky error flag.

Function
REQ-024 The state machine SHALL have states RUN, DRAIN, HALTED and ERROR.
REQ-025 In RUN, imem_req SHALL equal 1 iff occupancy+outstanding<DEPTH, so buffer overflow is impossible.
REQ-026 On imem_req&&imem_gnt: PC+=PC_INC (wraps at 2^ADDR_W), outstanding+=1, and the PC is pushed to an in-order tag queue.
REQ-027 On imem_rvalid, with drop count zero: {rdata, tagged PC} SHALL be enqueued, outstanding-=1.
REQ-028 instr_valid SHALL rise the cycle after enqueue; with 1-cycle memory, req accept to instr_valid = 2 cycles.
REQ-029 The head SHALL dequeue on instr_valid&&instr_ready; enqueue and dequeue may occur in the same cycle.
REQ-030 Sustained throughput SHALL be one instruction per cycle when memory grants every cycle and instr_ready=1.
REQ-031 On redirect_valid: PC<=redirect_pc, buffer flushed, drop count<=outstanding (including any accept in the same cycle), no request that cycle.
REQ-032 While drop count>0, each rvalid SHALL decrement it and be discarded; a response coincident with a redirect SHALL be discarded.
REQ-033 Redirect SHALL take priority over dequeue, enqueue and halt in the same cycle.
REQ-034 halt in RUN SHALL move to DRAIN: no new requests; outstanding responses are still enqueued; go to HALTED when outstanding=0.
REQ-035 In HALTED, imem_req=0; the buffer SHALL still drain to decode; a redirect SHALL return the state machine to RUN.
REQ-036 redirect_pc with any bit below log2(PC_INC) set, or imem_rvalid&&imem_err, SHALL set err and move to ERROR.
REQ-037 In ERROR, imem_req=0 and no enqueue occurs; err is cleared only by rst.
REQ-038 imem_addr SHALL be stable while imem_req=1 and imem_gnt=0.

Reset
REQ-039 rst SHALL asynchronously force: PC=RESET_PC, state=RUN, buffer empty, outstanding=0, drop=0, imem_req=0, instr_valid=0, err=0.
REQ-040 On release of rst, the first imem_req=1 SHALL occur on the first rising edge, with imem_addr=RESET_PC.
REQ-041 A rst asserted mid-transaction SHALL abandon in-flight reads; responses arriving after rst is released are the memory's responsibility to suppress.

Structure
REQ-042 Package fetch_pipe_pkg SHALL hold the state enum and the default parameter constants.
REQ-043 Sub-module fetch_fifo (parametrised width/depth, flush input, count output) SHALL implement the prefetch buffer.
REQ-044 The PC incrementer SHALL be a behavioural add of width ADDR_W; the carry out is discarded.

Verification
REQ-045 Reset release, gnt=1, 1-cycle memory, ready=1 -> instr_pc 0x0000,0x0002,0x0004 on consecutive cycles; first instr_valid in cycle 2.
REQ-046 ready=0, DEPTH=4 -> exactly 4 accepts, then imem_req=0; ready=1 restores one request per dequeue.
REQ-047 Redirect to 0x0100 with 3 reads outstanding -> 3 responses dropped; next instr_pc=0x0100.
REQ-048 PC=0xFFFE sequential -> next imem_addr=0x0000, and inc_PC at head 0xFFFE = 0x0000.
REQ-049 halt with 2 outstanding -> both delivered, state HALTED, imem_req=0; redirect to 0x0040 -> fetch resumes at 0x0040.
REQ-050 redirect_pc=0x0003, or rvalid with imem_err=1 -> err=1, imem_req=0 until rst.
